// File: rtl/u_pin_verify.sv
// PIN verification front-end: samples the card lookup on insertion, collects PIN entries,
// tracks remaining tries and keeps a per-card lock table that only reset clears.
module u_pin_verify #(
    parameter int CIS        = 4,
    parameter int DBD        = 16,
    parameter int Pass_width = 16,
    parameter int MAX_TRIES  = 3,
    parameter int TRY_W      = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  card_inserted,
    input  logic                  card_found_flag,
    input  logic [CIS-1:0]        card_index,
    input  logic [Pass_width-1:0] card_pass,
    input  logic                  pin_valid,
    input  logic [Pass_width-1:0] pin_in,
    input  logic                  session_end,
    output logic                  pin_ok,
    output logic                  pin_wrong,
    output logic                  card_invalid,
    output logic                  card_locked,
    output logic                  timeout_flag,
    output logic                  card_eject,
    output logic [TRY_W-1:0]      tries_left
);

    localparam int               TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = {TMR_W{1'b1}};
    localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRIES_ONE  = TRY_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK_CARD,
        ST_WAIT_PIN,
        ST_COMPARE,
        ST_AUTH,
        ST_LOCKED,
        ST_EJECT
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_insPrev;
    logic [DBD-1:0]        r_lock;
    logic [TMR_W-1:0]      r_timer;
    logic [CIS-1:0]        r_index;
    logic [Pass_width-1:0] r_pass;
    logic [Pass_width-1:0] r_pin;

    logic w_insRise;
    logic w_setInvalid;
    logic w_setTimeout;
    logic w_setWrong;
    logic w_lockSet;
    logic w_loadCard;
    logic w_loadPin;
    logic w_timerClr;
    logic w_triesDec;
    logic w_triesZero;

    assign w_insRise = card_inserted & ~r_insPrev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_setInvalid = 1'b0;
        w_setTimeout = 1'b0;
        w_setWrong   = 1'b0;
        w_lockSet    = 1'b0;
        w_loadCard   = 1'b0;
        w_loadPin    = 1'b0;
        w_timerClr   = 1'b0;
        w_triesDec   = 1'b0;
        w_triesZero  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_insRise) w_nextState = ST_CHECK_CARD;
            end
            ST_CHECK_CARD: begin
                if (!card_found_flag) begin
                    w_nextState  = ST_EJECT;
                    w_setInvalid = 1'b1;
                end else if (r_lock[card_index]) begin
                    w_nextState = ST_LOCKED;
                end else begin
                    w_nextState = ST_WAIT_PIN;
                    w_loadCard  = 1'b1;
                    w_timerClr  = 1'b1;
                end
            end
            ST_WAIT_PIN: begin
                if (pin_valid) begin
                    w_nextState = ST_COMPARE;
                    w_loadPin   = 1'b1;
                end else if (r_timer == TMR_LAST) begin
                    w_nextState  = ST_EJECT;
                    w_setTimeout = 1'b1;
                end
            end
            ST_COMPARE: begin
                if (r_pin == r_pass) begin
                    w_nextState = ST_AUTH;
                end else if (tries_left > TRIES_ONE) begin
                    w_nextState = ST_WAIT_PIN;
                    w_triesDec  = 1'b1;
                    w_setWrong  = 1'b1;
                    w_timerClr  = 1'b1;
                end else begin
                    w_nextState = ST_LOCKED;
                    w_triesZero = 1'b1;
                    w_lockSet   = 1'b1;
                end
            end
            ST_AUTH: begin
                if (session_end) w_nextState = ST_EJECT;
            end
            default: begin
                w_nextState = r_state;
            end
        endcase
        // Card removal beats every transition and its pulses, but a lock decision still sticks.
        if (r_state != ST_IDLE && !card_inserted) begin
            w_nextState  = ST_IDLE;
            w_setInvalid = 1'b0;
            w_setTimeout = 1'b0;
            w_setWrong   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_insPrev    <= 1'b0;
            r_lock       <= '0;
            r_timer      <= '0;
            r_index      <= '0;
            r_pass       <= '0;
            r_pin        <= '0;
            tries_left   <= '0;
            pin_ok       <= 1'b0;
            pin_wrong    <= 1'b0;
            card_invalid <= 1'b0;
            card_locked  <= 1'b0;
            timeout_flag <= 1'b0;
            card_eject   <= 1'b0;
        end else begin
            r_insPrev    <= card_inserted;
            pin_ok       <= (w_nextState == ST_AUTH);
            card_locked  <= (w_nextState == ST_LOCKED);
            card_eject   <= (w_nextState == ST_EJECT) && (r_state != ST_EJECT);
            pin_wrong    <= w_setWrong;
            card_invalid <= w_setInvalid;
            timeout_flag <= w_setTimeout;
            if (w_loadCard) begin
                r_index    <= card_index;
                r_pass     <= card_pass;
                tries_left <= TRIES_INIT;
            end else if (w_triesDec) begin
                tries_left <= tries_left - TRIES_ONE;
            end else if (w_triesZero) begin
                tries_left <= '0;
            end
            if (w_loadPin) r_pin <= pin_in;
            if (w_lockSet) r_lock[r_index] <= 1'b1;
            if (w_timerClr) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT_PIN && r_timer != TMR_MAX) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule
